// File: rtl/mips32_multicycle_control.sv
// Multi-cycle main control FSM for the MIPS32 shared-memory datapath.
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap unlisted opcodes (adds illegal_op).
module mips32_multicycle_control #(
  parameter int MEM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       pcwritecondn,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       lui,
  output logic       jal,
  output logic       instr_retire,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ORIEXEC = 4'd10,
    S_IWB     = 4'd11,
    S_LUIWB   = 4'd12,
    S_JAL     = 4'd13,
    S_TRAP    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam int          CW       = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_last;
  logic          in_mem_state;
  logic          op_known;

  assign cnt_last     = (cnt_q == CNT_LAST);
  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign op_known     = op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                                   OP_ORI, OP_LUI, OP_J, OP_JAL};
  assign state        = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Wait counter only advances inside memory states and clears on the exit cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (in_mem_state && !cnt_last) begin
      cnt_d = cnt_q + CW'(1);
    end
    case (state_q)
      S_FETCH:   if (cnt_last) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ORI:        state_d = S_ORIEXEC;
          OP_LUI:        state_d = S_LUIWB;
          OP_J:          state_d = S_JUMP;
          OP_JAL:        state_d = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:       state_d = S_TRAP;
`else
          default:       state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (cnt_last) state_d = S_MEMWB;
      S_MEMWR:   if (cnt_last) state_d = S_FETCH;
      S_EXEC:    state_d = S_RWB;
      S_ORIEXEC: state_d = S_IWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:    state_d = S_TRAP;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore outputs; everything is forced low while reset is held.
  always_comb begin
    pcwrite      = 1'b0;
    pcwritecond  = 1'b0;
    pcwritecondn = 1'b0;
    iord         = 1'b0;
    memread      = 1'b0;
    memwrite     = 1'b0;
    irwrite      = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    regwrite     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    aluop        = 2'b00;
    pcsource     = 2'b00;
    lui          = 1'b0;
    jal          = 1'b0;
    instr_retire = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_op   = 1'b0;
`endif
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = cnt_last;
          pcwrite = cnt_last;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
`ifndef MC_ILLEGAL_TRAP_EN
          instr_retire = !op_known;
`endif
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite     = 1'b1;
          memtoreg     = 1'b1;
          instr_retire = 1'b1;
        end
        S_MEMWR: begin
          memwrite     = 1'b1;
          iord         = 1'b1;
          instr_retire = cnt_last;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_RWB: begin
          regdst       = 1'b1;
          regwrite     = 1'b1;
          instr_retire = 1'b1;
        end
        S_BRANCH: begin
          alusrca      = 1'b1;
          aluop        = 2'b01;
          pcsource     = 2'b01;
          pcwritecond  = (op == OP_BEQ);
          pcwritecondn = (op == OP_BNE);
          instr_retire = 1'b1;
        end
        S_ORIEXEC: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = 2'b11;
        end
        S_IWB: begin
          regwrite     = 1'b1;
          instr_retire = 1'b1;
        end
        S_LUIWB: begin
          lui          = 1'b1;
          regwrite     = 1'b1;
          instr_retire = 1'b1;
        end
        S_JUMP: begin
          pcwrite      = 1'b1;
          pcsource     = 2'b10;
          instr_retire = 1'b1;
        end
        S_JAL: begin
          pcwrite      = 1'b1;
          pcsource     = 2'b10;
          jal          = 1'b1;
          regwrite     = 1'b1;
          instr_retire = 1'b1;
        end
`ifdef MC_ILLEGAL_TRAP_EN
        S_TRAP: illegal_op = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_multicycle_control.sv
// Directed self-checking bench for mips32_multicycle_control with MEM_LATENCY=2.
module tb_mips32_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       pcwrite, pcwritecond, pcwritecondn, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, lui, jal, instr_retire;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mips32_multicycle_control #(.MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .op(op),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .pcwritecondn(pcwritecondn),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .lui(lui), .jal(jal),
    .instr_retire(instr_retire),
`ifdef MC_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  logic [19:0] ctrl;
  assign ctrl = {pcwrite, pcwritecond, pcwritecondn, iord, memread, memwrite, irwrite,
                 memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
                 lui, jal, instr_retire};

  localparam logic [19:0] PCW = 20'h1 << 19, PWC = 20'h1 << 18, PWCN = 20'h1 << 17;
  localparam logic [19:0] IORD = 20'h1 << 16, MRD = 20'h1 << 15, MWR = 20'h1 << 14;
  localparam logic [19:0] IRW = 20'h1 << 13, M2R = 20'h1 << 12, RDST = 20'h1 << 11;
  localparam logic [19:0] RW = 20'h1 << 10, SRCA = 20'h1 << 9;
  localparam logic [19:0] SRCB01 = 20'h1 << 7, SRCB10 = 20'h2 << 7, SRCB11 = 20'h3 << 7;
  localparam logic [19:0] ALU01 = 20'h1 << 5, ALU10 = 20'h2 << 5, ALU11 = 20'h3 << 5;
  localparam logic [19:0] PCS01 = 20'h1 << 3, PCS10 = 20'h2 << 3;
  localparam logic [19:0] LUI = 20'h1 << 2, JAL = 20'h1 << 1, RET = 20'h1;

  localparam logic [19:0] E_F0   = MRD | SRCB01;
  localparam logic [19:0] E_F1   = MRD | SRCB01 | IRW | PCW;
  localparam logic [19:0] E_DEC  = SRCB11;
  localparam logic [19:0] E_MADR = SRCA | SRCB10;
  localparam logic [19:0] E_MRD  = MRD | IORD;
  localparam logic [19:0] E_MWB  = RW | M2R | RET;
  localparam logic [19:0] E_MWR0 = MWR | IORD;
  localparam logic [19:0] E_MWR1 = MWR | IORD | RET;
  localparam logic [19:0] E_EXEC = SRCA | ALU10;
  localparam logic [19:0] E_RWB  = RDST | RW | RET;
  localparam logic [19:0] E_BNE  = SRCA | ALU01 | PCS01 | PWCN | RET;
  localparam logic [19:0] E_BEQ  = SRCA | ALU01 | PCS01 | PWC | RET;
  localparam logic [19:0] E_ORI  = SRCA | SRCB10 | ALU11;
  localparam logic [19:0] E_IWB  = RW | RET;
  localparam logic [19:0] E_LUI  = LUI | RW | RET;
  localparam logic [19:0] E_J    = PCW | PCS10 | RET;
  localparam logic [19:0] E_JAL  = PCW | PCS10 | JAL | RW | RET;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check one cycle's state and control word, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [19:0] c);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_ctrl"}, 32'(ctrl), 32'(c));
    $display("cycle %s state=%0d ctrl=%05h", tag, state, ctrl);
    @(posedge clk); #1;
  endtask

  task automatic fetch_decode(input string tag, input logic [5:0] opcode);
    op = opcode;
    cyc({tag, "_f0"}, 4'd0, E_F0);
    cyc({tag, "_f1"}, 4'd0, E_F1);
    cyc({tag, "_dec"}, 4'd1, E_DEC);
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    op    = 6'b100011;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    reset = 1'b0;
    #1;

    fetch_decode("lw", 6'b100011);
    cyc("lw_adr", 4'd2, E_MADR);
    cyc("lw_rd0", 4'd3, E_MRD);
    cyc("lw_rd1", 4'd3, E_MRD);
    cyc("lw_wb", 4'd4, E_MWB);

    fetch_decode("rt", 6'b000000);
    cyc("rt_ex", 4'd6, E_EXEC);
    cyc("rt_wb", 4'd7, E_RWB);

    fetch_decode("ori", 6'b001101);
    cyc("ori_ex", 4'd10, E_ORI);
    cyc("ori_wb", 4'd11, E_IWB);

    fetch_decode("lui", 6'b001111);
    cyc("lui_wb", 4'd12, E_LUI);

    fetch_decode("bne", 6'b000101);
    cyc("bne_br", 4'd8, E_BNE);

    fetch_decode("beq", 6'b000100);
    cyc("beq_br", 4'd8, E_BEQ);

    fetch_decode("j", 6'b000010);
    cyc("j_jmp", 4'd9, E_J);

    fetch_decode("jal", 6'b000011);
    cyc("jal_jal", 4'd13, E_JAL);

    fetch_decode("sw", 6'b101011);
    cyc("sw_adr", 4'd2, E_MADR);
    cyc("sw_wr0", 4'd5, E_MWR0);
    cyc("sw_wr1", 4'd5, E_MWR1);

    op = 6'b111111;
    cyc("ill_f0", 4'd0, E_F0);
    cyc("ill_f1", 4'd0, E_F1);
`ifdef MC_ILLEGAL_TRAP_EN
    cyc("ill_dec", 4'd1, E_DEC);
    for (int i = 0; i < 12; i++) begin
      check("trap_illegal_op", 32'(illegal_op), 32'd1);
      cyc("trap", 4'd14, 20'h0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
`else
    cyc("ill_dec", 4'd1, E_DEC | RET);
    op = 6'b000000;
    cyc("ill_next_f0", 4'd0, E_F0);
    cyc("ill_next_f1", 4'd0, E_F1);
    cyc("ill_next_dec", 4'd1, E_DEC);
    cyc("ill_next_ex", 4'd6, E_EXEC);
    cyc("ill_next_wb", 4'd7, E_RWB);
`endif

    // Abort a store in its first write cycle.
    fetch_decode("swr", 6'b101011);
    cyc("swr_adr", 4'd2, E_MADR);
    check("swr_wr0_ctrl", 32'(ctrl), 32'(E_MWR0));
    reset = 1'b1;
    #1;
    check("swr_rst_state", 32'(state), 32'd0);
    check("swr_rst_ctrl", 32'(ctrl), 32'd0);
    @(posedge clk); #1;
    check("swr_hold_state", 32'(state), 32'd0);
    check("swr_hold_ctrl", 32'(ctrl), 32'd0);
    reset = 1'b0;
    #1;
    fetch_decode("post", 6'b000000);
    cyc("post_ex", 4'd6, E_EXEC);
    cyc("post_wb", 4'd7, E_RWB);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
